// File: rtl/scan_controller_pkg.sv
// Shared definitions for the Mandelbrot scan path: frame geometry and
// iteration-width defaults common to scan_controller, pointGenerator and the
// frame store, plus the scan FSM state encoding.
package scan_controller_pkg;

    localparam int unsigned H_RES_DEF = 640;  // pixels per line
    localparam int unsigned V_RES_DEF = 480;  // lines per frame
    localparam int unsigned HBI_DEF   = 64;   // MSB index of iteration count
    localparam int unsigned AW_DEF    = 19;   // pixel address width
    localparam int unsigned CW        = 12;   // coordinate width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/scan_controller_raster_counter.sv
// raster_counter: x/y/address counters for a raster walk of the frame.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          return to pixel (0,0), address 0 (priority over advance)
//   i_advance        step to the next pixel in raster order
//   o_x, o_y         current coordinates
//   o_addr           running linear address (y*H_RES+x without a multiplier)
//   o_last_pixel     current pixel is the final pixel of the frame
module raster_counter
    import scan_controller_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic [AW-1:0] o_addr,
    output logic          o_last_pixel
);

    localparam logic [CW-1:0] X_LAST   = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_RES - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic          w_last_col;

    assign w_last_col   = (r_x == X_LAST);
    assign o_last_pixel = w_last_col && (r_y == Y_LAST);
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_addr       = r_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (w_last_col) begin
                r_x <= '0;
                r_y <= r_y + C_ONE;
            end else begin
                r_x <= r_x + C_ONE;
            end
            r_addr <= r_addr + ADDR_ONE;
        end
    end

endmodule

// File: rtl/scan_controller.sv
// scan_controller: walks (x, y) over the frame in raster order, loads each
// point into pointGenerator, waits for its ready, and presents the captured
// iteration count with coordinates and address on a valid/ready pixel stream.
// One frame per accepted start pulse.
// Ports:
//   CLK, reset            clock, asynchronous active-low reset
//   start, abort          begin a frame when idle / abandon current frame
//   busy, frame_done      frame in progress / one-cycle end-of-frame pulse
//   x, y, pg_reset        point and load/hold to pointGenerator
//   pg_ready, pg_iteration  pointGenerator result
//   pix_valid, pix_ready  pixel stream handshake
//   pix_x, pix_y, pix_addr, pix_iter  pixel beat payload
module scan_controller
    import scan_controller_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned HBI   = HBI_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          frame_done,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pg_reset,
    input  logic          pg_ready,
    input  logic [HBI:0]  pg_iteration,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [AW-1:0] pix_addr,
    output logic [HBI:0]  pix_iter
);

    state_t        r_state;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_pg_reset;
    logic          r_pix_valid;
    logic [CW-1:0] r_pix_x;
    logic [CW-1:0] r_pix_y;
    logic [AW-1:0] r_pix_addr;
    logic [HBI:0]  r_pix_iter;

    logic          w_handshake;
    logic          w_last;
    logic          w_clear;
    logic          w_advance;
    logic [AW-1:0] w_addr;

    // pix_valid is always high in EMIT, so the state alone qualifies the beat.
    assign w_handshake = (r_state == ST_EMIT) && pix_ready;

    // Counters return to (0,0) on abort, on frame start and after the last
    // beat; otherwise they step once per transferred beat. An aborted beat
    // never advances.
    assign w_clear   = abort || ((r_state == ST_IDLE) && start) || (w_handshake && w_last);
    assign w_advance = w_handshake && !w_last;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .AW    (AW)
    ) u_raster (
        .i_clk        (CLK),
        .i_rst_n      (reset),
        .i_clear      (w_clear),
        .i_advance    (w_advance),
        .o_x          (x),
        .o_y          (y),
        .o_addr       (w_addr),
        .o_last_pixel (w_last)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pg_reset   <= 1'b1;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_addr   <= '0;
            r_pix_iter   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_pg_reset  <= 1'b1;
                r_pix_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_pg_reset <= 1'b1;
                        if (start) begin
                            r_busy  <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                    // pg_reset is still high across this edge, so
                    // pointGenerator loads the current point here.
                    ST_ISSUE: begin
                        r_pg_reset <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (pg_ready) begin
                            r_pix_iter  <= pg_iteration;
                            r_pix_x     <= x;
                            r_pix_y     <= y;
                            r_pix_addr  <= w_addr;
                            r_pix_valid <= 1'b1;
                            r_pg_reset  <= 1'b1;
                            r_state     <= ST_EMIT;
                        end
                    end
                    ST_EMIT: begin
                        if (pix_ready) begin
                            r_pix_valid <= 1'b0;
                            if (w_last) begin
                                r_frame_done <= 1'b1;
                                r_busy       <= 1'b0;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign pg_reset   = r_pg_reset;
    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_addr   = r_pix_addr;
    assign pix_iter   = r_pix_iter;

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller on a 4x3 frame with a small pointGenerator model.
module tb_scan_controller;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int HB = 7;
    localparam int A  = 4;
    localparam int NPIX = H * V;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          pg_reset;
    logic          pg_ready;
    logic [HB:0]   pg_iteration;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [11:0]   pix_x;
    logic [11:0]   pix_y;
    logic [A-1:0]  pix_addr;
    logic [HB:0]   pix_iter;

    always #5 CLK = ~CLK;

    scan_controller #(
        .H_RES (H),
        .V_RES (V),
        .HBI   (HB),
        .AW    (A)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .frame_done   (frame_done),
        .x            (x),
        .y            (y),
        .pg_reset     (pg_reset),
        .pg_ready     (pg_ready),
        .pg_iteration (pg_iteration),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_addr     (pix_addr),
        .pix_iter     (pix_iter)
    );

    // pointGenerator model: held at iteration 0 while pg_reset is high,
    // counts while low, ready once the count reaches k = x + y.
    // mode 1 models max_iterations = 0 (ready always, iteration 0).
    bit          mode = 1'b0;
    logic [HB:0] m_iter;

    always @(posedge CLK or negedge reset) begin
        if (!reset)        m_iter <= '0;
        else if (pg_reset) m_iter <= '0;
        else if (!pg_ready) m_iter <= m_iter + 1'b1;
    end

    assign pg_ready     = mode ? 1'b1 : (int'(m_iter) >= (int'(x) + int'(y)));
    assign pg_iteration = mode ? '0 : m_iter;

    int cyc = 0;
    int fd_count = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (frame_done) fd_count <= fd_count + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int y;
        int addr;
        int iter;
        int hold;
    } beat_t;

    beat_t tbl[NPIX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (pix_valid) begin
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL wait_valid: got timeout expected pix_valid within 60 cycles");
    endtask

    // Waits for a beat, checks its payload, optionally backpressures it for
    // b.hold cycles; the handshake happens on the edge after return.
    task automatic run_beat(input beat_t b, output int vcyc);
        bit ok;
        wait_valid(ok);
        vcyc = cyc;
        if (!ok) return;
        check("beat_x",    pix_x,    b.x);
        check("beat_y",    pix_y,    b.y);
        check("beat_addr", pix_addr, b.addr);
        check("beat_iter", pix_iter, b.iter);
        check("beat_busy", busy,     1);
        check("beat_pgrst", pg_reset, 1);
        if (b.hold > 0) begin
            pix_ready = 1'b0;
            for (int h = 0; h < b.hold; h++) begin
                @(negedge CLK);
                check("hold_valid", pix_valid, 1);
                check("hold_x",     pix_x,     b.x);
                check("hold_y",     pix_y,     b.y);
                check("hold_iter",  pix_iter,  b.iter);
                check("hold_pgrst", pg_reset,  1);
            end
            pix_ready = 1'b1;
        end
    endtask

    task automatic check_end_of_frame(input int fd_base);
        @(negedge CLK);
        check("eof_done",  frame_done, 1);
        check("eof_busy",  busy,       0);
        check("eof_valid", pix_valid,  0);
        check("eof_x",     x,          0);
        check("eof_y",     y,          0);
        @(negedge CLK);
        check("eof_done_pulse", frame_done, 0);
        check("eof_done_count", fd_count - fd_base, 1);
    endtask

    task automatic start_frame(output int c0);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        c0 = cyc;
    endtask

    initial begin
        int  c0;
        int  vc;
        int  prev;
        int  fd_base;
        bit  ok;
        beat_t b;

        for (int i = 0; i < NPIX; i++) begin
            tbl[i] = '{x: i % H, y: i / H, addr: i, iter: (i % H) + (i / H), hold: 0};
        end

        // ---- reset values
        #1 reset = 1'b0;
        #3;
        check("rst_pgrst", pg_reset,   1);
        check("rst_valid", pix_valid,  0);
        check("rst_busy",  busy,       0);
        check("rst_done",  frame_done, 0);
        check("rst_xy",    {x, y},     0);
        check("rst_addr",  pix_addr,   0);
        check("rst_pix",   {pix_x, pix_y, pix_iter}, 0);
        @(negedge CLK);
        reset = 1'b1;

        // ---- full frame, k = x + y, no backpressure
        mode = 1'b0;
        fd_base = fd_count;
        start_frame(c0);
        check("f1_busy", busy, 1);
        prev = c0;
        for (int i = 0; i < NPIX; i++) begin
            run_beat(tbl[i], vc);
            check("f1_spacing", vc - prev, (i == 0) ? 2 : tbl[i].iter + 3);
            prev = vc;
        end
        check_end_of_frame(fd_base);

        // ---- max_iterations = 0: 3-cycle pixels, backpressure, start while busy
        mode = 1'b1;
        fd_base = fd_count;
        start_frame(c0);
        check("z_issue_pgrst", pg_reset,  1);
        check("z_issue_valid", pix_valid, 0);
        @(negedge CLK);
        check("z_wait_pgrst",  pg_reset,  0);
        check("z_wait_valid",  pix_valid, 0);
        @(negedge CLK);
        check("z_emit_valid",  pix_valid, 1);
        check("z_emit_pgrst",  pg_reset,  1);
        check("z_latency",     cyc - c0,  2);
        check("z_emit_addr",   pix_addr,  0);
        prev = cyc;
        for (int i = 1; i < NPIX; i++) begin
            b = tbl[i];
            b.iter = 0;
            b.hold = (i == 5) ? 5 : 0;
            if (i == 8) begin
                @(negedge CLK);
                start = 1'b1;
                @(negedge CLK);
                start = 1'b0;
            end
            run_beat(b, vc);
            if (i != 6) check("z_spacing", vc - prev, 3);
            prev = vc;
            if (i == 5) begin
                @(negedge CLK);
                check("bp_next_x",     x,         2);
                check("bp_next_y",     y,         1);
                check("bp_next_pgrst", pg_reset,  1);
                check("bp_next_valid", pix_valid, 0);
            end
        end
        check_end_of_frame(fd_base);

        // ---- abort in WAIT at addr 7
        mode = 1'b0;
        fd_base = fd_count;
        start_frame(c0);
        for (int i = 0; i < 7; i++) run_beat(tbl[i], vc);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (pg_reset == 1'b0 && x == 12'd3 && y == 12'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_wait", ok, 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy",  busy,      0);
        check("abort_valid", pix_valid, 0);
        check("abort_pgrst", pg_reset,  1);
        check("abort_xy",    {x, y},    0);
        repeat (6) @(negedge CLK);
        check("abort_idle_valid", pix_valid, 0);
        check("abort_idle_busy",  busy,      0);
        check("abort_no_done",    fd_count - fd_base, 0);

        // restart begins at addr 0
        start_frame(c0);
        for (int i = 0; i < 3; i++) run_beat(tbl[i], vc);

        // start together with abort mid-frame -> idle
        @(negedge CLK);
        abort = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        start = 1'b0;
        check("sa_busy",  busy,      0);
        check("sa_valid", pix_valid, 0);
        check("sa_xy",    {x, y},    0);
        repeat (4) @(negedge CLK);
        check("sa_stay_idle", busy, 0);
        check("sa_no_done",   fd_count - fd_base, 0);

        // ---- asynchronous reset during EMIT
        start_frame(c0);
        for (int i = 0; i < 2; i++) run_beat(tbl[i], vc);
        wait_valid(ok);
        check("ar_pre_x",    pix_x,    2);
        check("ar_pre_iter", pix_iter, 2);
        #2 reset = 1'b0;
        #1;
        check("ar_pgrst", pg_reset,  1);
        check("ar_valid", pix_valid, 0);
        check("ar_busy",  busy,      0);
        check("ar_done",  frame_done, 0);
        check("ar_xy",    {x, y},    0);
        check("ar_addr",  pix_addr,  0);
        check("ar_pix",   {pix_x, pix_y, pix_iter}, 0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

endmodule
